// File: rtl/rho_rotate_pkg.sv
// rho_rotate_pkg: Keccak state geometry, rho offset table and FSM states.
package rho_rotate_pkg;
  localparam int NUM_ROW = 5;
  localparam int NUM_COLUMN = 5;
  localparam int NUM_PAGE = 64;
  localparam int NUM_CELLS = NUM_ROW * NUM_COLUMN * NUM_PAGE;
  localparam int LEN_ADDRESS = 11;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [5:0] RHO_OFFSET [5][5] = '{
    '{6'd0,  6'd36, 6'd3,  6'd41, 6'd18},
    '{6'd1,  6'd44, 6'd10, 6'd45, 6'd2},
    '{6'd62, 6'd6,  6'd43, 6'd15, 6'd61},
    '{6'd28, 6'd55, 6'd25, 6'd21, 6'd56},
    '{6'd27, 6'd20, 6'd39, 6'd8,  6'd14}
  };
  function automatic logic [LEN_ADDRESS-1:0] addr(input logic [2:0] i, input logic [2:0] j, input logic [5:0] k);
    return LEN_ADDRESS'(k) * LEN_ADDRESS'(25) + LEN_ADDRESS'(j) * LEN_ADDRESS'(5) + LEN_ADDRESS'(i);
  endfunction
endpackage

// File: rtl/rho_offset_rom.sv
// rho_offset_rom: combinational lane (x,y) to rho rotation offset lookup.
module rho_offset_rom
  import rho_rotate_pkg::*;
(
  input  logic [2:0] i_x,
  input  logic [2:0] i_y,
  output logic [5:0] o_offset
);
  always_comb o_offset = (i_x < 3'(NUM_COLUMN) && i_y < 3'(NUM_ROW)) ? RHO_OFFSET[i_x][i_y] : 6'd0;
endmodule

// File: rtl/rho_rotate_counter.sv
// rho_rotate_counter: wrapping up-counter 0..MAX with overflow strobe for chaining.
module rho_rotate_counter #(
  parameter int W = 3,
  parameter int MAX = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_ovf
);
  logic [W-1:0] r_count;
  assign o_count = r_count;
  assign o_ovf = i_en && r_count == W'(MAX);
  always_ff @(posedge i_clk)
    if (!i_rst) r_count <= '0;
    else if (i_en) r_count <= o_ovf ? '0 : r_count + 1'b1;
endmodule

// File: rtl/rho_rotate.sv
// rho_rotate: bit-serial Keccak rho step, one output cell per cycle with start/busy/done.
module rho_rotate
  import rho_rotate_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [NUM_CELLS-1:0] i_data_in,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [NUM_CELLS-1:0] o_data_out
);
  state_t r_state;
  logic r_req, r_busy, r_done;
  logic [NUM_CELLS-1:0] r_data_out;
  logic [2:0] w_i, w_j;
  logic [5:0] w_k, w_r, w_ks;
  logic w_calc, w_i_ovf, w_j_ovf, w_last;
  logic [LEN_ADDRESS-1:0] w_dst, w_src;
  assign w_calc = r_state == CALC;
  assign w_ks = w_k - w_r;
  assign w_dst = addr(w_i, w_j, w_k);
  assign w_src = addr(w_i, w_j, w_ks);
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_data_out = r_data_out;
  rho_rotate_counter #(.W(3), .MAX(NUM_ROW - 1)) u_cnt_i (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(w_calc), .o_count(w_i), .o_ovf(w_i_ovf));
  rho_rotate_counter #(.W(3), .MAX(NUM_COLUMN - 1)) u_cnt_j (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(w_i_ovf), .o_count(w_j), .o_ovf(w_j_ovf));
  rho_rotate_counter #(.W(6), .MAX(NUM_PAGE - 1)) u_cnt_k (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(w_j_ovf), .o_count(w_k), .o_ovf(w_last));
  rho_offset_rom u_rom (.i_x(w_j), .i_y(w_i), .o_offset(w_r));
  // r_req spends one IDLE cycle latching start so CALC begins one edge after the start sample.
  always_ff @(posedge i_clk)
    if (!i_rst) begin
      r_state <= IDLE;
      r_req <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_data_out <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req <= i_start && !r_req;
          if (r_req) begin
            r_state <= CALC;
            r_busy <= 1'b1;
          end
        end
        CALC: begin
          r_data_out[w_dst] <= i_data_in[w_src];
          if (w_last) begin
            r_state <= DONE;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
        default: begin
          r_done <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
endmodule

// File: doc/rho_rotate.md
Name: rho_rotate

Overview:
- Keccak rho step, placed directly downstream of the column-parity (theta) stage.
- Consumes the 1600-bit theta state and rotates each of the 25 lanes along the page (z) axis by that lane's fixed rho offset.
- Bit-serial: one output cell is written per cycle over 1600 cycles. The block has its own FSM with a start/busy/done handshake.
- The result is held in an output register that feeds the next permutation stage (pi).

Parameters:
- NUM_ROW, 5: rows (y); index i.
- NUM_COLUMN, 5: columns (x); index j.
- NUM_PAGE, 64: lane bits (z); index k. Must be a power of 2.
- NUM_CELLS, 1600: NUM_ROW*NUM_COLUMN*NUM_PAGE.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  request one rho pass. Sampled only in IDLE.
- data_in  in  NUM_CELLS  theta state. Upstream holds it stable from the start cycle until done.
- busy  out  1  high while cells are being written.
- done  out  1  one-cycle pulse when the pass is complete.
- data_out  out  NUM_CELLS  rho result register.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. On rst=0 at a rising edge:
  - state=IDLE; i, j, k = 0.
  - data_out=0, busy=0, done=0.
  - Reset mid-pass aborts the pass immediately; no done is produced.
- Cell address: addr(i,j,k) = k*25 + j*5 + i. Width LEN_ADDRESS=11.
- Lane mapping: lane x=j, y=i. Offset r=RHO_OFFSET[j][i], 6-bit, already reduced mod 64.
- Per-cycle write in CALC: data_out[addr(i,j,k)] <= data_in[addr(i,j,ks)], where ks=(k - r) mod 64. This is native 6-bit wrap-around subtraction; no explicit modulo logic.
- Scan order:
  - i fastest, wraps 4->0 and carries into j.
  - j wraps 4->0 and carries into k.
  - k wraps 63->0 and marks the last cell.
- FSM:
  - IDLE: busy=0, done=0. start=1 -> CALC with counters at 0. start=0 -> stay.
  - CALC: busy=1. Writes one cell per cycle. After the write of (i=4, j=4, k=63) -> DONE and counters return to 0. Exactly 1600 cycles are spent in CALC.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Start handling: start is ignored in CALC and DONE. A start asserted in the DONE cycle is dropped. It must be re-asserted in IDLE.
- Latency: start sampled at edge E.
  - busy is high in the cycles following edges E+1 .. E+1600.
  - done is high in the cycle following edge E+1601.
  - data_out is final once done is high.
- Output retention:
  - data_out holds its value indefinitely in IDLE and DONE.
  - A new pass overwrites cells progressively. Bits not yet written keep their previous-pass value.
- Wrap-around: ks wraps below 0 (for example k=0, r=1 -> ks=63). The full rotation over 64 bits is exact.
- Boundary lane: lane (0,0) has r=0 and is copied unchanged.

Decomposition:
- Shared package (ISA include), alongside the existing NUM_ROW/NUM_COLUMN/NUM_PAGE/NUM_CELLS/LEN_ADDRESS:
  - RHO_OFFSET[x][y] constant table (mod 64), rows y=0..4, entries x=0..4:
    - y=0: 0 1 62 28 27
    - y=1: 36 44 6 55 20
    - y=2: 3 10 43 25 39
    - y=3: 41 45 15 21 8
    - y=4: 18 2 61 56 14
  - FSM state encodings IDLE, CALC, DONE.
- Reuse the existing wrapping Counter for i, j and k, chained by overflow.
- One natural sub-module: rho_offset_rom, combinational (x,y) -> 6-bit offset. Keep the FSM, the address arithmetic and the data_out register in rho_rotate.

Test Plan:
- Reset: hold rst=0 for 3 cycles with arbitrary data_in -> data_out=0, busy=0, done=0. start during reset is ignored.
- Single bit:
  - data_in has only bit 5 set (i=0, j=1, k=0; r=1).
  - Pulse start -> busy high exactly 1600 cycles, then one done pulse.
  - data_out has only bit 30 set (k=1).
- Wrap-around:
  - data_in has only bit 1599 set (i=4, j=4, k=63; r=14).
  - -> only data_out bit 349 set (k=13).
- Zero-offset lane and full rotations:
  - data_in = lane (0,0) all ones plus a random pattern.
  - -> lane (0,0) unchanged.
  - All 25 lanes match a golden rho model.
  - Repeat with 20 random states.
- Handshake abuse:
  - start held high through the whole pass -> exactly one pass and one done per IDLE sample.
  - start pulsed mid-CALC -> ignored.
  - start during DONE -> dropped.
- Reset mid-pass:
  - Assert rst=0 after 800 CALC cycles -> next cycle busy=0, data_out=0, no done.
  - A following start runs a full correct pass.
